// File: rtl/digit_scroller.sv
// Scrolling 6-digit marquee window over a writable buffer of 5-bit digit codes.
// Optional feature macro: SCROLL_BLINK_EN (adds 'blink' input to flash the held window in STOP).
module digit_scroller #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned MSG_LEN  = 16,
  parameter int unsigned AW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_data,
  input  logic          run,
  input  logic          dir,
  input  logic          restart,
`ifdef SCROLL_BLINK_EN
  input  logic          blink,
`endif
  output logic [4:0]    data_0,
  output logic [4:0]    data_1,
  output logic [4:0]    data_2,
  output logic [4:0]    data_3,
  output logic [4:0]    data_4,
  output logic [4:0]    data_5,
  output logic [AW-1:0] pos,
  output logic          wrap
);

  localparam int unsigned CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CntLast = CW'(TICK_DIV - 1);
  localparam logic [AW-1:0] PosLast = AW'(MSG_LEN - 1);
  localparam logic [4:0]    CodeOff = 5'd20;

  typedef enum logic {StStop, StRun} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pos_q, pos_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  logic          hide;
  logic [4:0]    msg_q [MSG_LEN];
  logic [4:0]    msg_d [MSG_LEN];
  logic [4:0]    win_q [6];
  logic [4:0]    win_d [6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StStop;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop:  if (run)  state_d = StRun;
      StRun:   if (!run) state_d = StStop;
      default: state_d = StStop;
    endcase
  end

  assign tick = (state_q == StRun) && (cnt_q == CntLast);

  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (restart || state_d == StStop) cnt_d = '0;
    else if (state_q == StRun)        cnt_d = tick ? '0 : cnt_q + CW'(1);

    if (restart) begin
      pos_d = '0;
    end else if (tick) begin
      if (!dir) begin
        if (pos_q == PosLast) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + AW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = PosLast;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - AW'(1);
        end
      end
    end

    // Out-of-range addresses match no entry and are dropped.
    for (int unsigned i = 0; i < MSG_LEN; i++) begin
      msg_d[i] = msg_q[i];
      if (wr_en && (32'(wr_addr) == i)) msg_d[i] = wr_data;
    end

    // Window is built from next-state pos/buffer so data_5 always matches pos.
    for (int unsigned k = 0; k < 6; k++) begin
      win_d[5-k] = CodeOff;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        if (((32'(pos_d) + k) % MSG_LEN) == i) win_d[5-k] = msg_d[i];
      end
      if (hide) win_d[5-k] = CodeOff;
    end
  end

`ifdef SCROLL_BLINK_EN
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          bphase_q, bphase_d;

  // Free-running blink prescaler; phase realigns to "shown" whenever STOP is entered.
  always_comb begin
    bcnt_d   = bcnt_q + CW'(1);
    bphase_d = bphase_q;
    if (state_q == StRun && state_d == StStop) begin
      bcnt_d   = '0;
      bphase_d = 1'b0;
    end else if (bcnt_q == CntLast) begin
      bcnt_d   = '0;
      bphase_d = ~bphase_q;
    end
    hide = (state_d == StStop) && blink && bphase_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q   <= '0;
      bphase_q <= 1'b0;
    end else begin
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
    end
  end
`else
  assign hide = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      wrap_q <= 1'b0;
      for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= CodeOff;
      for (int unsigned k = 0; k < 6; k++)       win_q[k] <= CodeOff;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= msg_d[i];
      for (int unsigned k = 0; k < 6; k++)       win_q[k] <= win_d[k];
    end
  end

  assign data_0 = win_q[0];
  assign data_1 = win_q[1];
  assign data_2 = win_q[2];
  assign data_3 = win_q[3];
  assign data_4 = win_q[4];
  assign data_5 = win_q[5];
  assign pos    = pos_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_digit_scroller.sv
// Scoreboard bench for digit_scroller: stimulus queues expected window/pos/wrap per cycle,
// a negedge monitor pops and compares.
module tb_digit_scroller;
  localparam int unsigned TD = 4;
  localparam int unsigned ML = 8;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [4:0]    wr_data = '0;
  logic          run = 1'b0;
  logic          dir = 1'b0;
  logic          restart = 1'b0;
`ifdef SCROLL_BLINK_EN
  logic          blink = 1'b0;
`endif
  logic [4:0]    d0, d1, d2, d3, d4, d5;
  logic [AW-1:0] pos;
  logic          wrap;
  logic [29:0]   dout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wrap_cnt = 0;
  logic [4:0] msg [ML];

  typedef struct {
    int            cyc;
    logic [AW-1:0] pos;
    logic          wrap;
    logic [29:0]   data;
    string         name;
  } exp_t;
  exp_t sb[$];

  digit_scroller #(.TICK_DIV(TD), .MSG_LEN(ML), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .dir(dir), .restart(restart),
`ifdef SCROLL_BLINK_EN
    .blink(blink),
`endif
    .data_0(d0), .data_1(d1), .data_2(d2), .data_3(d3), .data_4(d4), .data_5(d5),
    .pos(pos), .wrap(wrap)
  );

  assign dout = {d5, d4, d3, d2, d1, d0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk({e.name, "_missed_cycle"}, 64'(cyc), 64'(e.cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk(e.name, {28'd0, pos, wrap, dout}, {28'd0, e.pos, e.wrap, e.data});
    end
  end

  function automatic logic [29:0] pack6(input int a5, a4, a3, a2, a1, a0);
    return {5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [29:0] win(input int p);
    logic [29:0] w;
    for (int k = 0; k < 6; k++) w[(5-k)*5 +: 5] = msg[(p + k) % ML];
    return w;
  endfunction

  task automatic expect_now(input int p, input logic w, input logic [29:0] d, input string name);
    exp_t e;
    e.cyc = cyc; e.pos = AW'(p); e.wrap = w; e.data = d; e.name = name;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = 5'(d);
    if (a < ML) msg[a] = 5'(d);
    cycles(1);
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] all20;
    int base;
    int hid;
    all20 = pack6(20, 20, 20, 20, 20, 20);
    for (int i = 0; i < ML; i++) msg[i] = 5'd20;

    #2 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);  expect_now(0, 1'b0, all20, "reset");
    cycles(20); expect_now(0, 1'b0, all20, "hold_stop");

    for (int i = 0; i < ML; i++) wr(i, i);
    expect_now(0, 1'b0, pack6(0, 1, 2, 3, 4, 5), "load");

    base = wrap_cnt;
    run = 1'b1; dir = 1'b0;
    cycles(4); expect_now(0, 1'b0, win(0), "pre_step1");
    cycles(1); expect_now(1, 1'b0, pack6(1, 2, 3, 4, 5, 6), "step1");
    for (int k = 2; k <= 8; k++) begin
      cycles(3); expect_now(k - 1, 1'b0, win(k - 1), "pre_step");
      cycles(1); expect_now(k % 8, (k == 8), win(k % 8), "step");
    end
    cycles(1); expect_now(0, 1'b0, win(0), "wrap_end");
    chk("wrap_once", 64'(wrap_cnt - base), 64'd1);

    dir = 1'b1;
    cycles(3); expect_now(7, 1'b1, pack6(7, 0, 1, 2, 3, 4), "dir_right_wrap");
    cycles(1); expect_now(7, 1'b0, win(7), "wrap_clear");
    cycles(15); expect_now(3, 1'b0, win(3), "at_pos3");
    cycles(3);
    restart = 1'b1; dir = 1'b0;
    cycles(1);
    restart = 1'b0;
    expect_now(0, 1'b0, win(0), "restart_on_tick");
    cycles(3); expect_now(0, 1'b0, win(0), "restart_hold");
    cycles(1); expect_now(1, 1'b0, win(1), "step_after_restart");

    run = 1'b0; restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    expect_now(0, 1'b0, win(0), "stop_restart");
    cycles(5); expect_now(0, 1'b0, win(0), "stop_hold");
    wr(2, 17); expect_now(0, 1'b0, pack6(0, 1, 17, 3, 4, 5), "write_visible");
    wr(9, 19); expect_now(0, 1'b0, pack6(0, 1, 17, 3, 4, 5), "write_oob");
    wr(6, 18); expect_now(0, 1'b0, pack6(0, 1, 17, 3, 4, 5), "write_hidden");

`ifdef SCROLL_BLINK_EN
    blink = 1'b1;
`endif
    hid = 0;
    for (int i = 0; i < 16; i++) begin
      cycles(1);
      if (dout == all20) hid++;
    end
`ifdef SCROLL_BLINK_EN
    chk("blink_hidden_cycles", 64'(hid), 64'd8);
`else
    chk("stop_steady", 64'(hid), 64'd0);
`endif
    run = 1'b1;
    hid = 0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (dout == all20) hid++;
    end
    chk("run_no_blink", 64'(hid), 64'd0);
    expect_now(1, 1'b0, pack6(1, 17, 3, 4, 5, 18), "resume_scroll");
`ifdef SCROLL_BLINK_EN
    blink = 1'b0;
`endif

    cycles(6);
    #2 rst_n = 1'b0;
    for (int i = 0; i < ML; i++) msg[i] = 5'd20;
    #1 chk("async_reset", {28'd0, pos, wrap, dout}, {28'd0, 5'd0, 1'b0, all20});
    run = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(3); expect_now(0, 1'b0, all20, "post_reset_stop");

    cycles(2);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
